// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds FSM state encodings, the register specifier width and sizing helpers.
// Pure declarations: no logic, no latency, no flow control.
package pipeline_hazard_ctrl_pkg;

   // Register specifier width used by the ID/EX hazard compare
   localparam int REG_ADDR_W_DEF = 5;

   // FSM encodings; kept as plain 2-bit constants so older tools and
   // waveform scripts that decode ctrl_state numerically still work
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MDU_BUSY = 2'd1;
   localparam logic [1:0] ST_MDU_DONE = 2'd2;
   localparam logic [1:0] ST_ILLEGAL  = 2'd3;

   // Width needed to hold the MDU down-counter preload value (lat-1)
   function automatic int mdu_cnt_w(input int lat);
      return $clog2(lat) + 1;
   endfunction

endpackage : pipeline_hazard_ctrl_pkg

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter with synchronous clear, enable and natural wrap.
// Latency: count visible one cycle after the enabled cycle.
// No backpressure: counts every enabled cycle, clear wins over enable.
module hazard_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear has priority, otherwise increment and wrap modulo 2^W
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule : hazard_perf_cnt

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for load-use hazards, taken branches and the multi-cycle MDU.
// Latency: enables/flushes are combinational from state and inputs; counters lag one cycle.
// Backpressure: stalls PC, IF/ID and ID/EX for one cycle per load-use and MDU_LAT cycles per MDU op.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int MDU_LAT    = 32,
   parameter int CNT_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_uses_rt_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  ex_mdu_start_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  ifid_flush_o,
   output logic                  idex_write_o,
   output logic                  idex_flush_o,
   output logic                  exmem_bubble_o,
   output logic                  mdu_busy_o,
   output logic [1:0]            ctrl_state_o,
   output logic [CNT_W-1:0]      stall_cycles_o,
   output logic [CNT_W-1:0]      flush_count_o
);

   localparam int MCW = mdu_cnt_w(MDU_LAT);

   logic [1:0]     state_q;
   logic [1:0]     state_d;
   logic [MCW-1:0] mdu_cnt_q;
   logic [MCW-1:0] mdu_cnt_d;
   logic           load_use;
   logic           stall_en;
   logic           flush_en;

   // Load in EX writing a non-zero register that the ID instruction reads
   assign load_use = ex_mem_read_i
                   & (ex_rt_i != '0)
                   & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

   // Next state and MDU down-counter; branch beats MDU start beats load-use in RUN
   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (ex_branch_taken_i) begin
               state_d = ST_RUN;
            end else if (ex_mdu_start_i) begin
               mdu_cnt_d = MCW'(MDU_LAT - 1);
               state_d   = ST_MDU_BUSY;
            end
         end
         ST_MDU_BUSY: begin
            mdu_cnt_d = mdu_cnt_q - MCW'(1);
            if (mdu_cnt_q == MCW'(1)) begin
               state_d = ST_MDU_DONE;
            end
         end
         ST_MDU_DONE: begin
            // EX still holds the finishing MDU op, so its start/branch/load bits are stale
            state_d = ST_RUN;
         end
         default: begin
            state_d   = ST_RUN;
            mdu_cnt_d = '0;
         end
      endcase
   end

   // FSM and MDU counter registers; reset aborts any MDU op in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         mdu_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mdu_cnt_q <= mdu_cnt_d;
      end
   end

   // Output decode: defaults let the pipeline flow, reset forces NOPs everywhere
   always_comb begin
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_write_o   = 1'b1;
      idex_flush_o   = 1'b0;
      exmem_bubble_o = 1'b0;
      if (rst_i) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         ifid_flush_o   = 1'b1;
         idex_write_o   = 1'b0;
         idex_flush_o   = 1'b1;
         exmem_bubble_o = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (ex_branch_taken_i) begin
                  // Wrong-path instructions in IF/ID and ID/EX are squashed
                  ifid_flush_o = 1'b1;
                  idex_flush_o = 1'b1;
               end else if (ex_mdu_start_i) begin
                  pc_write_o     = 1'b0;
                  ifid_write_o   = 1'b0;
                  idex_write_o   = 1'b0;
                  exmem_bubble_o = 1'b1;
               end else if (load_use) begin
                  // Hold IF/ID and PC, send a bubble into EX; the bubble clears
                  // ex_mem_read next cycle so the stall cannot retrigger
                  pc_write_o   = 1'b0;
                  ifid_write_o = 1'b0;
                  idex_flush_o = 1'b1;
               end
            end
            ST_MDU_BUSY: begin
               pc_write_o     = 1'b0;
               ifid_write_o   = 1'b0;
               idex_write_o   = 1'b0;
               exmem_bubble_o = 1'b1;
            end
            default: begin
               // MDU_DONE and the unreachable encoding keep the flow-through defaults
            end
         endcase
      end
   end

   assign mdu_busy_o   = (state_q == ST_MDU_BUSY);
   assign ctrl_state_o = state_q;

   assign stall_en = ~rst_i & ~pc_write_o;
   assign flush_en = ~rst_i & (state_q == ST_RUN) & ex_branch_taken_i;

   hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .en_i  (stall_en),
      .cnt_o (stall_cycles_o)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clr_i (rst_i),
      .en_i  (flush_en),
      .cnt_o (flush_count_o)
   );

endmodule : pipeline_hazard_ctrl
